// File: rtl/queue_enq_scheduler.sv
// Round-robin enqueue scheduler: packs up to EnqWidth grants onto
// lanes 0..G-1 and tracks free queue entries from enq/deq fires.
module queue_enq_scheduler #(
    parameter  int Depth       = 8,
    parameter  int EnqWidth    = 2,
    parameter  int DeqWidth    = 2,
    parameter  int NumReq      = 4,
    localparam int CntWidth    = $clog2(Depth + 1),
    localparam int ReqIdxWidth = $clog2(NumReq)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NumReq-1:0]               req_valid_i,
    output logic [NumReq-1:0]               req_ready_o,
    output logic [EnqWidth-1:0]             enq_fire_o,
    output logic [EnqWidth*ReqIdxWidth-1:0] lane_src_o,
    input  logic [DeqWidth-1:0]             deq_fire_i,
    input  logic                            flush_i,
    output logic [CntWidth-1:0]             free_cnt_o,
    output logic                            full_o,
    output logic                            empty_o
);

    logic [CntWidth-1:0]    r_free;
    logic [ReqIdxWidth-1:0] r_rr_ptr;

    int                     w_nvalid;
    int                     w_ndeq;
    int                     w_g;
    int                     w_cnt;
    int                     w_sum;
    int                     w_free_next;
    int                     w_rr_next;
    int                     w_pos;
    logic [ReqIdxWidth-1:0] w_idx;
    logic [ReqIdxWidth-1:0] w_last;
    logic                   w_viol;

    // Grant count: bounded by lanes, credits and demand; none on flush/reset
    always_comb begin
        w_nvalid = 0;
        w_ndeq   = 0;
        for (int i = 0; i < NumReq; i++) begin
            w_nvalid = w_nvalid + int'(req_valid_i[i]);
        end
        for (int i = 0; i < DeqWidth; i++) begin
            w_ndeq = w_ndeq + int'(deq_fire_i[i]);
        end
        w_g = EnqWidth;
        if (int'(r_free) < w_g) begin
            w_g = int'(r_free);
        end
        if (w_nvalid < w_g) begin
            w_g = w_nvalid;
        end
        if (flush_i || !rstn) begin
            w_g = 0;
        end
    end

    // Circular scan from the pointer; k-th winner is packed onto lane k
    always_comb begin
        req_ready_o = '0;
        enq_fire_o  = '0;
        lane_src_o  = '0;
        w_cnt       = 0;
        w_pos       = 0;
        w_idx       = '0;
        w_last      = r_rr_ptr;
        for (int off = 0; off < NumReq; off++) begin
            w_pos = int'(r_rr_ptr) + off;
            if (w_pos >= NumReq) begin
                w_pos = w_pos - NumReq;
            end
            w_idx = ReqIdxWidth'(w_pos);
            if (req_valid_i[w_idx] && (w_cnt < w_g)) begin
                req_ready_o[w_idx] = 1'b1;
                for (int k = 0; k < EnqWidth; k++) begin
                    if (k == w_cnt) begin
                        enq_fire_o[k] = 1'b1;
                        lane_src_o[k*ReqIdxWidth +: ReqIdxWidth] = w_idx;
                    end
                end
                w_cnt  = w_cnt + 1;
                w_last = w_idx;
            end
        end
    end

    // Next-state: pointer past last winner, credits with saturation
    always_comb begin
        w_rr_next = int'(r_rr_ptr);
        if (w_g > 0) begin
            w_rr_next = int'(w_last) + 1;
            if (w_rr_next >= NumReq) begin
                w_rr_next = 0;
            end
        end
        w_viol      = (Depth - int'(r_free)) < w_ndeq;
        w_sum       = int'(r_free) - w_g + w_ndeq;
        w_free_next = (w_sum > Depth) ? Depth : w_sum;
        if (flush_i) begin
            w_free_next = Depth;
        end
    end

    // State registers; dequeues beyond occupancy are a protocol error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_free   <= CntWidth'(Depth);
            r_rr_ptr <= '0;
        end else begin
`ifndef SYNTHESIS
            assert (flush_i || !w_viol);
`endif
            r_free   <= CntWidth'(w_free_next);
            r_rr_ptr <= ReqIdxWidth'(w_rr_next);
        end
    end

    assign free_cnt_o = r_free;
    assign full_o     = (r_free == '0);
    assign empty_o    = (r_free == CntWidth'(Depth));

endmodule
